// File: rtl/bp_fe_bht_gshare.sv
// ---------------------------------------------------------------------------------------------
// bp_fe_bht_gshare
//
// Gshare branch history table for the front end. An array of ctr_width_p-bit saturating
// counters is indexed by the PC index XOR a speculative global history register (GHR).
// After reset an init sweep writes every entry to weakly not-taken; only then are reads,
// trains and GHR updates accepted.
//
// Predictions are registered (1-cycle latency) and come out together with the GHR value that
// formed the index. That checkpoint is later handed back for training (ghist_w_i) or for GHR
// repair on a mispredict (restore_ghist_i).
//
// Optional build macro:
//   BP_FE_BHT_BYPASS_EN - when defined, a read and a train that hit the same hashed entry in
//                         the same cycle return the post-update counter MSB. When undefined the
//                         read returns the pre-update value and no forwarding logic exists.
//
// Ports:
//   clk_i            clock
//   reset_i          synchronous, active-high reset; restarts the init sweep, clears the GHR
//   init_done_o      high once the init sweep is complete
//   r_v_i, idx_r_i   read request and PC index
//   predict_v_o      prediction valid, 1 cycle after an accepted read
//   predict_o        predicted taken (counter MSB)
//   ghist_o          GHR used for the read (checkpoint), aligned with predict_o
//   spec_v_i         shift spec_taken_i into the GHR
//   spec_taken_i     speculative direction
//   w_v_i            train request
//   idx_w_i          train PC index
//   ghist_w_i        checkpoint GHR captured at prediction time
//   taken_i          resolved direction
//   restore_v_i      mispredict: repair the GHR (wins over spec_v_i)
//   restore_ghist_i  checkpoint of the mispredicted branch
//   restore_taken_i  resolved direction of that branch
// ---------------------------------------------------------------------------------------------

module bp_fe_bht_gshare #(
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned ghist_width_p   = 8,
  parameter int unsigned ctr_width_p     = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  output logic                       init_done_o,

  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] idx_r_i,
  output logic                       predict_v_o,
  output logic                       predict_o,
  output logic [ghist_width_p-1:0]   ghist_o,

  input  logic                       spec_v_i,
  input  logic                       spec_taken_i,

  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] idx_w_i,
  input  logic [ghist_width_p-1:0]   ghist_w_i,
  input  logic                       taken_i,

  input  logic                       restore_v_i,
  input  logic [ghist_width_p-1:0]   restore_ghist_i,
  input  logic                       restore_taken_i
);

  localparam int unsigned els_lp = 1 << bht_idx_width_p;

  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [ctr_width_p-1:0] init_val_lp = ctr_width_p'((1 << (ctr_width_p - 1)) - 1);
  localparam logic [ctr_width_p-1:0] ctr_max_lp  = {ctr_width_p{1'b1}};
  localparam logic [ctr_width_p-1:0] ctr_min_lp  = '0;

  typedef enum logic [0:0] {
    StInit,
    StReady
  } state_e;

  // -------------------------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------------------------
  state_e                     state_q;
  logic [bht_idx_width_p-1:0] sweep_ptr_q;
  logic [ghist_width_p-1:0]   ghr_q;
  logic [ghist_width_p-1:0]   ghr_d;
  logic                       predict_v_q;
  logic                       predict_q;
  logic [ghist_width_p-1:0]   ghist_q;

  logic [ctr_width_p-1:0]     mem_q [els_lp];

  logic ready;
  assign ready       = (state_q == StReady);
  assign init_done_o = ready;

  // Requests only count once the sweep is done and outside reset.
  logic rd_fire;
  logic wr_fire;
  logic spec_fire;
  logic restore_fire;

  assign rd_fire      = ready & r_v_i   & ~reset_i;
  assign wr_fire      = ready & w_v_i   & ~reset_i;
  assign spec_fire    = ready & spec_v_i;
  assign restore_fire = ready & restore_v_i;

  // -------------------------------------------------------------------------------------------
  // Index hashing (GHR zero-extended to the index width)
  // -------------------------------------------------------------------------------------------
  logic [bht_idx_width_p-1:0] ghr_ext;
  logic [bht_idx_width_p-1:0] ghist_w_ext;
  logic [bht_idx_width_p-1:0] rd_idx;
  logic [bht_idx_width_p-1:0] wr_idx;

  assign ghr_ext     = bht_idx_width_p'(ghr_q);
  assign ghist_w_ext = bht_idx_width_p'(ghist_w_i);
  assign rd_idx      = idx_r_i ^ ghr_ext;
  assign wr_idx      = idx_w_i ^ ghist_w_ext;

  // -------------------------------------------------------------------------------------------
  // Training: saturating counter update
  // -------------------------------------------------------------------------------------------
  logic [ctr_width_p-1:0] ctr_w_old;
  logic [ctr_width_p-1:0] ctr_w_new;

  assign ctr_w_old = mem_q[wr_idx];

  always_comb begin
    ctr_w_new = ctr_w_old;
    if (taken_i) begin
      if (ctr_w_old != ctr_max_lp) begin
        ctr_w_new = ctr_w_old + ctr_width_p'(1);
      end
    end else begin
      if (ctr_w_old != ctr_min_lp) begin
        ctr_w_new = ctr_w_old - ctr_width_p'(1);
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // Single write port shared by the init sweep and training
  // -------------------------------------------------------------------------------------------
  logic                       mem_we;
  logic [bht_idx_width_p-1:0] mem_waddr;
  logic [ctr_width_p-1:0]     mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sweep_ptr_q;
    mem_wdata = init_val_lp;
    if (!reset_i) begin
      if (state_q == StInit) begin
        mem_we = 1'b1;
      end else if (wr_fire) begin
        mem_we    = 1'b1;
        mem_waddr = wr_idx;
        mem_wdata = ctr_w_new;
      end
    end
  end

  // Counter array carries no reset; the init sweep gives it a defined value.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------------------------
  logic [ctr_width_p-1:0] rd_ctr;
  logic                   rd_taken;

  assign rd_ctr = mem_q[rd_idx];

`ifdef BP_FE_BHT_BYPASS_EN
  // Forward the counter being written this cycle when both ports hit the same entry.
  always_comb begin
    rd_taken = rd_ctr[ctr_width_p-1];
    if (wr_fire && (wr_idx == rd_idx)) begin
      rd_taken = ctr_w_new[ctr_width_p-1];
    end
  end
`else
  // Read-before-write: a same-cycle train is seen by reads issued from the next cycle on.
  assign rd_taken = rd_ctr[ctr_width_p-1];
`endif

  // -------------------------------------------------------------------------------------------
  // GHR next state: restore beats speculative shift
  // -------------------------------------------------------------------------------------------
  logic [ghist_width_p-1:0] ghr_restore;
  logic [ghist_width_p-1:0] ghr_spec;

  if (ghist_width_p == 1) begin : g_ghr_one
    assign ghr_restore = restore_taken_i;
    assign ghr_spec    = spec_taken_i;
  end else begin : g_ghr_multi
    assign ghr_restore = {restore_ghist_i[ghist_width_p-2:0], restore_taken_i};
    assign ghr_spec    = {ghr_q[ghist_width_p-2:0], spec_taken_i};
  end

  always_comb begin
    ghr_d = ghr_q;
    if (restore_fire) begin
      ghr_d = ghr_restore;
    end else if (spec_fire) begin
      ghr_d = ghr_spec;
    end
  end

  // -------------------------------------------------------------------------------------------
  // FSM, GHR and registered outputs
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StInit;
      sweep_ptr_q <= '0;
      ghr_q       <= '0;
      predict_v_q <= 1'b0;
      predict_q   <= 1'b0;
      ghist_q     <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          sweep_ptr_q <= sweep_ptr_q + bht_idx_width_p'(1);
          if (sweep_ptr_q == {bht_idx_width_p{1'b1}}) begin
            state_q <= StReady;
          end
        end
        StReady: begin
          state_q <= StReady;
        end
        default: begin
          state_q <= StInit;
        end
      endcase

      ghr_q       <= ghr_d;
      predict_v_q <= rd_fire;
      if (rd_fire) begin
        predict_q <= rd_taken;
        ghist_q   <= ghr_q;
      end
    end
  end

  assign predict_v_o = predict_v_q;
  assign predict_o   = predict_q;
  assign ghist_o     = ghist_q;

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// Bench for bp_fe_bht_gshare at default parameters (512 entries, 8-bit GHR, 2-bit counters).
// Reads push their expected {predict, ghist} into a queue; a monitor pops and compares whenever
// predict_v_o is high. Init-sweep and reset behaviour is checked inline.

module tb_bp_fe_bht_gshare;

  localparam int unsigned IW = 9;
  localparam int unsigned GW = 8;
  localparam int unsigned CW = 2;

  logic          clk_i;
  logic          reset_i;
  logic          init_done_o;
  logic          r_v_i;
  logic [IW-1:0] idx_r_i;
  logic          predict_v_o;
  logic          predict_o;
  logic [GW-1:0] ghist_o;
  logic          spec_v_i;
  logic          spec_taken_i;
  logic          w_v_i;
  logic [IW-1:0] idx_w_i;
  logic [GW-1:0] ghist_w_i;
  logic          taken_i;
  logic          restore_v_i;
  logic [GW-1:0] restore_ghist_i;
  logic          restore_taken_i;

  bp_fe_bht_gshare #(
    .bht_idx_width_p(IW),
    .ghist_width_p  (GW),
    .ctr_width_p    (CW)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .init_done_o    (init_done_o),
    .r_v_i          (r_v_i),
    .idx_r_i        (idx_r_i),
    .predict_v_o    (predict_v_o),
    .predict_o      (predict_o),
    .ghist_o        (ghist_o),
    .spec_v_i       (spec_v_i),
    .spec_taken_i   (spec_taken_i),
    .w_v_i          (w_v_i),
    .idx_w_i        (idx_w_i),
    .ghist_w_i      (ghist_w_i),
    .taken_i        (taken_i),
    .restore_v_i    (restore_v_i),
    .restore_ghist_i(restore_ghist_i),
    .restore_taken_i(restore_taken_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          pred;
    logic [GW-1:0] ghist;
  } exp_t;

  exp_t sb_q[$];

`ifdef BP_FE_BHT_BYPASS_EN
  localparam logic CollisionPred = 1'b1;
`else
  localparam logic CollisionPred = 1'b0;
`endif

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Monitor: every valid prediction must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (predict_v_o === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_predict: got predict_v_o=1 expected no prediction");
        end else begin
          e = sb_q.pop_front();
          if (predict_o !== e.pred || ghist_o !== e.ghist) begin
            errors++;
            $display("FAIL predict: got pred=%0b ghist=%02h expected pred=%0b ghist=%02h",
                     predict_o, ghist_o, e.pred, e.ghist);
          end
        end
      end
    end
  end

  // Inputs change on the falling edge, the DUT samples on the rising edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_read(input logic [IW-1:0] idx, input logic pred, input logic [GW-1:0] gh);
    r_v_i   = 1'b1;
    idx_r_i = idx;
    sb_q.push_back('{pred: pred, ghist: gh});
    step();
    r_v_i = 1'b0;
  endtask

  task automatic do_train(input logic [IW-1:0] idx, input logic [GW-1:0] gh, input logic tk);
    w_v_i     = 1'b1;
    idx_w_i   = idx;
    ghist_w_i = gh;
    taken_i   = tk;
    step();
    w_v_i = 1'b0;
  endtask

  task automatic do_spec(input logic tk);
    spec_v_i     = 1'b1;
    spec_taken_i = tk;
    step();
    spec_v_i = 1'b0;
  endtask

  task automatic do_restore(input logic [GW-1:0] gh, input logic tk);
    restore_v_i     = 1'b1;
    restore_ghist_i = gh;
    restore_taken_i = tk;
    step();
    restore_v_i = 1'b0;
  endtask

  // Release reset and walk the full sweep; requests in cycle 100 must be ignored.
  task automatic run_init();
    reset_i = 1'b0;
    for (int c = 1; c <= 512; c++) begin
      if (c == 100) begin
        r_v_i        = 1'b1;
        idx_r_i      = '0;
        spec_v_i     = 1'b1;
        spec_taken_i = 1'b1;
        restore_v_i  = 1'b1;
        restore_ghist_i = 8'hFF;
        restore_taken_i = 1'b1;
      end
      step();
      r_v_i       = 1'b0;
      spec_v_i    = 1'b0;
      restore_v_i = 1'b0;
      if (c == 1)   check_bit("init_done_c1", init_done_o, 1'b0);
      if (c == 100) check_bit("init_read_ignored", predict_v_o, 1'b0);
      if (c == 511) check_bit("init_done_c511", init_done_o, 1'b0);
      if (c == 512) check_bit("init_done_c512", init_done_o, 1'b1);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    r_v_i = 1'b0; idx_r_i = '0;
    spec_v_i = 1'b0; spec_taken_i = 1'b0;
    w_v_i = 1'b0; idx_w_i = '0; ghist_w_i = '0; taken_i = 1'b0;
    restore_v_i = 1'b0; restore_ghist_i = '0; restore_taken_i = 1'b0;
    @(negedge clk_i);
    step();
    step();
    check_bit("reset_init_done", init_done_o, 1'b0);
    check_bit("reset_predict_v", predict_v_o, 1'b0);
    check_bit("reset_predict", predict_o, 1'b0);
    checks++;
    if (ghist_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_ghist: got %02h expected 00", ghist_o);
    end

    run_init();

    // Freshly initialised entry: weakly not-taken, GHR still 0.
    do_read(9'h1A3, 1'b0, 8'h00);

    // Saturation on entry 5 (GHR 0).
    repeat (3) do_train(9'h005, 8'h00, 1'b1);      // 01->10->11->11
    do_read(9'h005, 1'b1, 8'h00);
    do_train(9'h005, 8'h00, 1'b0);                 // 10
    do_read(9'h005, 1'b1, 8'h00);
    repeat (2) do_train(9'h005, 8'h00, 1'b0);      // 01, 00
    do_read(9'h005, 1'b0, 8'h00);
    repeat (2) do_train(9'h005, 8'h00, 1'b0);      // stays 00
    do_train(9'h005, 8'h00, 1'b1);                 // 01
    do_read(9'h005, 1'b0, 8'h00);
    do_train(9'h005, 8'h00, 1'b1);                 // 10
    do_read(9'h005, 1'b1, 8'h00);

    // Hashing: GHR 0 -> 1 -> 3 -> 7.
    repeat (3) do_spec(1'b1);
    do_read(9'h000, 1'b0, 8'h07);                  // entry 7 = 01
    do_train(9'h000, 8'h07, 1'b1);                 // entry 7 = 10
    do_read(9'h000, 1'b1, 8'h07);
    do_read(9'h007, 1'b0, 8'h07);                  // entry 0 = 01
    do_train(9'h007, 8'h00, 1'b1);                 // entry 7 = 11
    // Read with a same-cycle spec shift uses the old GHR; GHR becomes 0F.
    spec_v_i = 1'b1; spec_taken_i = 1'b1;
    do_read(9'h000, 1'b1, 8'h07);
    spec_v_i = 1'b0;
    do_read(9'h008, 1'b1, 8'h0F);                  // 008 ^ 0F = entry 7

    // Restore beats spec: {0x80[6:0], 0} = 00.
    spec_v_i = 1'b1; spec_taken_i = 1'b1;
    do_restore(8'h80, 1'b0);
    spec_v_i = 1'b0;
    do_read(9'h005, 1'b1, 8'h00);                  // entry 5 = 10
    do_restore(8'h41, 1'b1);                       // {0x41[6:0], 1} = 83
    do_read(9'h083, 1'b0, 8'h83);                  // entry 0 = 01
    do_restore(8'h00, 1'b0);                       // GHR = 00

    // Collision on entry 0A0 (counter 01): read + taken-train in one cycle.
    w_v_i = 1'b1; idx_w_i = 9'h0A0; ghist_w_i = 8'h00; taken_i = 1'b1;
    do_read(9'h0A0, CollisionPred, 8'h00);
    w_v_i = 1'b0;
    do_read(9'h0A0, 1'b1, 8'h00);                  // now 10 in both builds

    do_spec(1'b1);                                 // GHR = 01
    do_read(9'h001, 1'b0, 8'h01);                  // entry 0 = 01
    step();

    // Reset mid-sweep at sweep_ptr = 200.
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    repeat (200) step();
    reset_i = 1'b1;
    step();
    check_bit("midreset_init_done", init_done_o, 1'b0);
    run_init();
    do_read(9'h005, 1'b0, 8'h00);                  // entry 5 back to 01, GHR cleared
    do_read(9'h0A0, 1'b0, 8'h00);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding predictions expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
